// File: rtl/conv_tile_loader.sv
// Pixel-stream to tile assembler feeding the 3x3 convolution stage.
// Holds one WIDTH_IN x WIDTH_IN tile plus the mask/bias configuration registers.
module conv_tile_loader #(
    parameter int unsigned WIDTH_IN = 10,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [31:0]                         in_data,
    input  logic                                in_valid,
    input  logic                                in_sof,
    output logic                                in_ready,
    output logic [WIDTH_IN*WIDTH_IN-1:0][31:0]  tile_pixels,
    output logic                                tile_valid,
    input  logic                                tile_ready,
    input  logic                                cfg_we,
    input  logic [3:0]                          cfg_addr,
    input  logic [31:0]                         cfg_wdata,
    output logic [8:0][31:0]                    mask,
    output logic [31:0]                         bias,
    output logic [CNT_W-1:0]                    tile_count,
    output logic                                sync_err,
    output logic                                cfg_err,
    input  logic                                err_clr
);

    localparam int unsigned N      = WIDTH_IN * WIDTH_IN;
    localparam int unsigned SLOT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N - 1);

    typedef enum logic {FILL, FULL} state_t;

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d, wr_slot;
    logic                accept, restart, wr_pix, handoff;
    logic                sync_set, cfg_set, cfg_wr;

    // Next-state, slot counter and write/event strobes
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        wr_slot  = slot_q;
        wr_pix   = 1'b0;
        handoff  = 1'b0;
        sync_set = 1'b0;
        cfg_set  = 1'b0;
        cfg_wr   = 1'b0;
        accept   = in_valid & in_ready;
        restart  = accept & in_sof & (slot_q != '0);
        case (state_q)
            FILL: begin
                cfg_wr = cfg_we;
                if (accept) begin
                    wr_pix = 1'b1;
                    if (restart) begin
                        // SOF mid-tile: drop the partial tile and restart at slot 0
                        wr_slot  = '0;
                        slot_d   = SLOT_W'(1);
                        sync_set = 1'b1;
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                        if (slot_q == LAST_SLOT) begin
                            state_d = FULL;
                        end
                    end
                end
            end
            FULL: begin
                cfg_set = cfg_we;
                if (tile_ready) begin
                    state_d = FILL;
                    slot_d  = '0;
                    handoff = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State, handshake flags and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FILL;
            slot_q     <= '0;
            in_ready   <= 1'b0;
            tile_valid <= 1'b0;
            tile_count <= '0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            in_ready   <= (state_d == FILL);
            tile_valid <= (state_d == FULL);
            if (handoff) begin
                tile_count <= tile_count + CNT_W'(1);
            end
        end
    end

    // Tile storage; only written while filling, so stable in FULL
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tile_pixels <= '0;
        end else if (wr_pix) begin
            tile_pixels[wr_slot] <= in_data;
        end
    end

    // Mask/bias configuration registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask <= '0;
            bias <= '0;
        end else if (cfg_wr) begin
            if (cfg_addr <= 4'd8) begin
                mask[cfg_addr] <= cfg_wdata;
            end else if (cfg_addr == 4'd9) begin
                bias <= cfg_wdata;
            end
        end
    end

    // Sticky errors; a set event in the same cycle overrides err_clr
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_err <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            if (sync_set) begin
                sync_err <= 1'b1;
            end else if (err_clr) begin
                sync_err <= 1'b0;
            end
            if (cfg_set) begin
                cfg_err <= 1'b1;
            end else if (err_clr) begin
                cfg_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_tile_loader.sv
// Randomized self-checking bench for conv_tile_loader against a tile-level model.
// CNT_W is reduced so the tile_count wrap is reachable in a short run.
module tb_conv_tile_loader;

    localparam int unsigned WIDTH_IN = 10;
    localparam int unsigned N        = WIDTH_IN * WIDTH_IN;
    localparam int unsigned CNT_W    = 4;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [31:0]            in_data = '0;
    logic                   in_valid = 1'b0;
    logic                   in_sof = 1'b0;
    logic                   in_ready;
    logic [N-1:0][31:0]     tile_pixels;
    logic                   tile_valid;
    logic                   tile_ready = 1'b0;
    logic                   cfg_we = 1'b0;
    logic [3:0]             cfg_addr = '0;
    logic [31:0]            cfg_wdata = '0;
    logic [8:0][31:0]       mask;
    logic [31:0]            bias;
    logic [CNT_W-1:0]       tile_count;
    logic                   sync_err;
    logic                   cfg_err;
    logic                   err_clr = 1'b0;

    conv_tile_loader #(.WIDTH_IN(WIDTH_IN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
        .tile_pixels(tile_pixels), .tile_valid(tile_valid), .tile_ready(tile_ready),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .mask(mask), .bias(bias), .tile_count(tile_count),
        .sync_err(sync_err), .cfg_err(cfg_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: expected tile contents, fill position, handoff count
    logic [31:0] m_tile [N];
    int          m_cnt     = 0;
    int          exp_count = 0;
    int          gap_pct   = 0;

    function automatic void model_reset();
        for (int k = 0; k < N; k++) m_tile[k] = '0;
        m_cnt     = 0;
        exp_count = 0;
    endfunction

    function automatic int tile_bad(output int first);
        int bad = 0;
        first = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (tile_pixels[k] !== m_tile[k]) begin
                bad++;
                first = k;
            end
        end
        return bad;
    endfunction

    // Offer one pixel (after optional random idle cycles) until accepted
    task automatic push(input logic [31:0] d, input logic sof);
        int   waited = 0;
        logic acc    = 1'b0;
        while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_data = d; in_sof = sof; in_valid = 1'b1;
        do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            waited++;
        end while (!acc && waited < 300);
        in_valid = 1'b0; in_sof = 1'b0;
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout: pixel %h not accepted within 300 cycles", d);
        end else begin
            if (sof && m_cnt != 0) m_cnt = 0;
            m_tile[m_cnt] = d;
            m_cnt = (m_cnt + 1) % N;
        end
    endtask

    task automatic push_n(input int cnt);
        for (int i = 0; i < cnt; i++) push($urandom, 1'b0);
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d, input logic clr);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d; err_clr = clr;
        @(posedge clk); #1;
        cfg_we = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        int first, bad;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        n_checks++; if (tile_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tile_valid got %b exp 0", tile_valid); end
        n_checks++; if (tile_count !== '0) begin n_fail++; $display("FAIL reset_tile_count got %0d exp 0", tile_count); end
        n_checks++; if ({sync_err, cfg_err} !== 2'b00) begin n_fail++; $display("FAIL reset_errs got %b exp 00", {sync_err, cfg_err}); end
        n_checks++; if (mask !== '0 || bias !== '0) begin n_fail++; $display("FAIL reset_cfg got mask=%h bias=%h exp 0", mask, bias); end
        bad = tile_bad(first);
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL reset_tile %0d bad slots, slot %0d got %h exp 0", bad, first, tile_pixels[first]); end
        @(negedge clk); reset_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL release_in_ready_early got %b exp 0", in_ready); end
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_stream();
        int first, bad;
        tile_ready = 1'b1;
        for (int k = 0; k < N; k++) push(32'(k), 1'b0);
        n_checks++; if (tile_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL stream_full got valid=%b ready=%b exp 1/0", tile_valid, in_ready); end
        for (int k = 0; k < N; k++) m_tile[k] = 32'(k);
        bad = tile_bad(first);
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL stream_tile %0d bad, slot %0d got %h exp %h", bad, first, tile_pixels[first], m_tile[first]); end
        @(posedge clk); #1;
        exp_count++;
        n_checks++; if (tile_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_handoff got valid=%b ready=%b exp 0/1", tile_valid, in_ready); end
        n_checks++; if (tile_count !== CNT_W'(exp_count)) begin n_fail++; $display("FAIL stream_count got %0d exp %0d", tile_count, exp_count); end
    endtask

    task automatic test_backpressure();
        int first, bad;
        int accepts = 0;
        tile_ready = 1'b0;
        push_n(N);
        in_data = 32'hDEAD_BEEF; in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk); if (in_ready) accepts++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++; if (accepts !== 0) begin n_fail++; $display("FAIL hold_accepts got %0d exp 0", accepts); end
        n_checks++; if (tile_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid got %b exp 1", tile_valid); end
        bad = tile_bad(first);
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL hold_tile %0d bad, slot %0d got %h exp %h", bad, first, tile_pixels[first], m_tile[first]); end
        tile_ready = 1'b1;
        @(posedge clk); #1;
        exp_count++;
        n_checks++; if (tile_count !== CNT_W'(exp_count)) begin n_fail++; $display("FAIL hold_count got %0d exp %0d", tile_count, exp_count); end
        push_n(N);
        exp_count++;
        bad = tile_bad(first);
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL hold_next_tile %0d bad, slot %0d got %h exp %h", bad, first, tile_pixels[first], m_tile[first]); end
    endtask

    task automatic test_random_gaps();
        int first, bad;
        tile_ready = 1'b1;
        gap_pct = 50;
        for (int t = 0; t < 3; t++) begin
            push_n(N);
            exp_count++;
            bad = tile_bad(first);
            n_checks++; if (tile_valid !== 1'b1 || bad !== 0) begin n_fail++; $display("FAIL gaps_tile%0d valid=%b %0d bad, slot %0d got %h exp %h", t, tile_valid, bad, first, tile_pixels[first], m_tile[first]); end
        end
        gap_pct = 0;
        @(posedge clk); #1;
        n_checks++; if (tile_count !== CNT_W'(exp_count)) begin n_fail++; $display("FAIL gaps_count got %0d exp %0d", tile_count, exp_count); end
        n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL gaps_sync_err got %b exp 0", sync_err); end
    endtask

    task automatic test_sof_resync();
        int first, bad;
        tile_ready = 1'b1;
        push_n(37);
        push(32'h0000_AAAA, 1'b1);
        n_checks++; if (sync_err !== 1'b1) begin n_fail++; $display("FAIL sof_sync_err got %b exp 1", sync_err); end
        n_checks++; if (tile_pixels[0] !== 32'h0000_AAAA) begin n_fail++; $display("FAIL sof_slot0 got %h exp 0000aaaa", tile_pixels[0]); end
        push_n(N - 2);
        n_checks++; if (tile_valid !== 1'b0) begin n_fail++; $display("FAIL sof_early_valid got %b exp 0", tile_valid); end
        push_n(1);
        exp_count++;
        bad = tile_bad(first);
        n_checks++; if (tile_valid !== 1'b1 || bad !== 0) begin n_fail++; $display("FAIL sof_tile valid=%b %0d bad, slot %0d got %h exp %h", tile_valid, bad, first, tile_pixels[first], m_tile[first]); end
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL sof_err_clr got %b exp 0", sync_err); end
        push($urandom, 1'b1);
        n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL sof_at_slot0 sync_err got %b exp 0", sync_err); end
        push_n(N - 1);
        exp_count++;
        bad = tile_bad(first);
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL sof_slot0_tile %0d bad, slot %0d got %h exp %h", bad, first, tile_pixels[first], m_tile[first]); end
        @(posedge clk); #1;
    endtask

    task automatic test_config();
        logic [8:0][31:0] exp_mask;
        for (int k = 0; k < 9; k++) begin
            cfg_write(4'(k), 32'(k + 1), 1'b0);
            exp_mask[k] = 32'(k + 1);
            n_checks++; if (mask[k] !== exp_mask[k]) begin n_fail++; $display("FAIL cfg_mask%0d got %h exp %h", k, mask[k], exp_mask[k]); end
        end
        cfg_write(4'd9, 32'd7, 1'b0);
        n_checks++; if (bias !== 32'd7) begin n_fail++; $display("FAIL cfg_bias got %h exp 7", bias); end
        tile_ready = 1'b0;
        push_n(N);
        // Write in FULL with err_clr the same cycle: dropped, error still set
        cfg_write(4'd3, 32'hDEAD, 1'b1);
        n_checks++; if (mask !== exp_mask) begin n_fail++; $display("FAIL cfg_full_drop got mask[3]=%h exp 4", mask[3]); end
        n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_set got %b exp 1", cfg_err); end
        tile_ready = 1'b1;
        @(posedge clk); #1;
        exp_count++;
        cfg_write(4'd12, 32'h1234_5678, 1'b0);
        n_checks++; if (mask !== exp_mask || bias !== 32'd7) begin n_fail++; $display("FAIL cfg_addr12 changed regs, bias=%h exp 7", bias); end
        n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_sticky got %b exp 1", cfg_err); end
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_clr got %b exp 0", cfg_err); end
        n_checks++; if (tile_count !== CNT_W'(exp_count)) begin n_fail++; $display("FAIL cfg_count got %0d exp %0d", tile_count, exp_count); end
    endtask

    task automatic test_reset_wrap();
        int first, bad;
        tile_ready = 1'b1;
        push_n(50);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        bad = tile_bad(first);
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL midreset_tile %0d bad, slot %0d got %h exp 0", bad, first, tile_pixels[first]); end
        n_checks++; if (in_ready !== 1'b0 || tile_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_flags got ready=%b valid=%b exp 0/0", in_ready, tile_valid); end
        n_checks++; if (mask !== '0 || bias !== '0 || tile_count !== '0) begin n_fail++; $display("FAIL midreset_regs bias=%h count=%0d exp 0", bias, tile_count); end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        for (int t = 0; t < (1 << CNT_W) - 1; t++) begin
            push_n(N);
            exp_count++;
        end
        @(posedge clk); #1;
        n_checks++; if (tile_count !== CNT_W'(exp_count)) begin n_fail++; $display("FAIL wrap_max got %0d exp %0d", tile_count, exp_count); end
        push_n(N);
        exp_count++;
        @(posedge clk); #1;
        n_checks++; if (tile_count !== '0) begin n_fail++; $display("FAIL wrap_zero got %0d exp 0", tile_count); end
        bad = tile_bad(first);
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL wrap_tile %0d bad, slot %0d got %h exp %h", bad, first, tile_pixels[first], m_tile[first]); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_random_gaps();
        test_sof_resync();
        test_config();
        test_reset_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
